// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with memory ready handshake and retire counter.
// Define MULTICYCLE_CTRL_TRAP_EN to trap illegal instructions into HALT; otherwise they are skipped.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      Instr,
  input  logic             MemReady,
  input  logic             Zero,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic             MemtoReg,
  output logic             RegW,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUCtl,
  output logic [4:0]       DR,
  output logic [4:0]       SR1,
  output logic [4:0]       SR2,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Halt
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0] op, fn;
  logic       is_r, legal, retire;
  logic [2:0] r_alu;
  logic [4:0] wb_dr;
  assign op     = Instr[31:26];
  assign fn     = Instr[5:0];
  assign is_r   = op == OP_R;
  assign legal  = is_r ? (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                       : (op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
  assign r_alu  = fn == 6'b100010 ? 3'b110 : fn == 6'b100100 ? 3'b000 :
                  fn == 6'b100101 ? 3'b001 : fn == 6'b101010 ? 3'b111 : 3'b010;
  assign wb_dr  = is_r ? Instr[15:11] : Instr[20:16];
  assign SR1    = Instr[25:21];
  assign SR2    = Instr[20:16];
  assign State  = state_q;
  assign InstrCount = cnt_q;
  assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, retire};
`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign Halt = state_q == S_HALT;
`else
  assign Halt = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Outputs are gated by RST_N so nothing strobes while reset is held.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    MemtoReg = 1'b0;
    RegW     = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    ALUCtl   = 3'b000;
    DR       = 5'd0;
    if (RST_N) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'b01;
            ALUCtl  = 3'b010;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ALUCtl  = 3'b010;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_d = legal ? S_EXEC : S_HALT;
`else
          state_d = legal ? S_EXEC : S_FETCH;
`endif
        end
        S_EXEC: begin
          if (op == OP_J) begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (op == OP_BEQ) begin
            ALUSrcA = 1'b1;
            ALUCtl  = 3'b110;
            PCSrc   = 2'b01;
            PCWrite = Zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            ALUSrcA = 1'b1;
            ALUSrcB = is_r ? 2'b00 : 2'b10;
            ALUCtl  = is_r ? r_alu : 3'b010;
            state_d = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = op == OP_LW;
          MemWrite = op == OP_SW;
          if (MemReady) begin
            retire  = op == OP_SW;
            state_d = op == OP_SW ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          DR       = wb_dr;
          MemtoReg = op == OP_LW;
          RegW     = wb_dr != 5'd0;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle scoreboard for multicycle_ctrl (counter narrowed to 4 bits to reach wrap).
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam logic [7:0] IRW = 8'h80, PCW = 8'h40, MR = 8'h20, MW = 8'h10,
                         IOD = 8'h08, SA = 8'h04, M2R = 8'h02, RW = 8'h01;
  logic CLK = 1'b0, RST_N = 1'b0, MemReady = 1'b0, Zero = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic IRWrite, PCWrite, MemRead, MemWrite, IorD, ALUSrcA, MemtoReg, RegW, Halt;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUCtl, State;
  logic [4:0] DR, SR1, SR2;
  logic [CW-1:0] InstrCount;
  logic [CW-1:0] exp_cnt = '0;
  logic [37:0] eq[$];
  string nq[$];
  int compared = 0, mismatched = 0;
  multicycle_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .Instr(Instr), .MemReady(MemReady), .Zero(Zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg), .RegW(RegW),
    .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl), .DR(DR), .SR1(SR1), .SR2(SR2),
    .State(State), .InstrCount(InstrCount), .Halt(Halt)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (eq.size() != 0) begin
      logic [37:0] act, e;
      string n;
      act = {State, IRWrite, PCWrite, MemRead, MemWrite, IorD, ALUSrcA, MemtoReg, RegW,
             PCSrc, ALUSrcB, ALUCtl, DR, SR1, SR2, InstrCount, Halt};
      e = eq.pop_front();
      n = nq.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got %h want %h (st/strb/pcs/srcb/alu/dr/sr1/sr2/cnt/halt)", n, act, e);
      end
    end
  end
  initial begin
    #200000;
    mismatched++;
    $display("FAIL timeout: directed sequence did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  task automatic step(input string nm, input logic rdy, input logic z, input logic [2:0] st,
                      input logic [7:0] sb, input logic [1:0] pcs, input logic [1:0] srcb,
                      input logic [2:0] alu, input logic [4:0] dr, input logic ret, input logic hlt);
    MemReady = rdy;
    Zero = z;
    nq.push_back(nm);
    eq.push_back({st, sb, pcs, srcb, alu, dr, Instr[25:21], Instr[20:16], exp_cnt, hlt});
    @(posedge CLK);
    #1;
    if (ret) exp_cnt++;
  endtask
  task automatic fd(input string nm, input logic [31:0] ins);
    Instr = ins;
    step({nm, "_f"}, 1'b1, 1'b0, 3'd0, IRW | PCW | MR, 2'd0, 2'd1, 3'd2, 5'd0, 1'b0, 1'b0);
    step({nm, "_d"}, 1'b1, 1'b0, 3'd1, 8'h00, 2'd0, 2'd3, 3'd2, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic rtype(input string nm, input logic [31:0] ins, input logic [2:0] alu);
    fd(nm, ins);
    step({nm, "_e"}, 1'b1, 1'b0, 3'd2, SA, 2'd0, 2'd0, alu, 5'd0, 1'b0, 1'b0);
    step({nm, "_w"}, 1'b1, 1'b0, 3'd4, RW, 2'd0, 2'd0, 3'd0, 5'd1, 1'b1, 1'b0);
  endtask
  task automatic reset_cycle(input string nm);
    RST_N = 1'b0;
    exp_cnt = '0;
    #1;
    compared++;
    if ({IRWrite, PCWrite, MemRead, MemWrite, RegW, State, InstrCount, Halt} !== '0) begin
      mismatched++;
      $display("FAIL %s_async: strobes/state/count/halt not cleared during reset", nm);
    end
    step(nm, 1'b1, 1'b0, 3'd0, 8'h00, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    RST_N = 1'b1;
  endtask
  initial begin
    @(posedge CLK);
    #1;
    Instr = 32'h00430820;
    reset_cycle("rst0");
    rtype("add", 32'h00430820, 3'b010);
    fd("sw", 32'hAC220004);
    step("sw_e", 1'b1, 1'b0, 3'd2, SA, 2'd0, 2'd2, 3'd2, 5'd0, 1'b0, 1'b0);
    step("sw_m0", 1'b0, 1'b0, 3'd3, IOD | MW, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    step("sw_m1", 1'b0, 1'b0, 3'd3, IOD | MW, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    reset_cycle("rst_mid_sw");
    step("post_rst_f", 1'b0, 1'b0, 3'd0, MR, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    fd("sw2", 32'hAC220004);
    step("sw2_e", 1'b1, 1'b0, 3'd2, SA, 2'd0, 2'd2, 3'd2, 5'd0, 1'b0, 1'b0);
    step("sw2_m", 1'b1, 1'b0, 3'd3, IOD | MW, 2'd0, 2'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    fd("lw", 32'h8C220004);
    step("lw_e", 1'b0, 1'b0, 3'd2, SA, 2'd0, 2'd2, 3'd2, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      step("lw_mwait", 1'b0, 1'b0, 3'd3, IOD | MR, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    step("lw_m", 1'b1, 1'b0, 3'd3, IOD | MR, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    step("lw_w", 1'b1, 1'b0, 3'd4, RW | M2R, 2'd0, 2'd0, 3'd0, 5'd2, 1'b1, 1'b0);
    fd("beq1", 32'h10220003);
    step("beq1_e", 1'b1, 1'b1, 3'd2, SA | PCW, 2'd1, 2'd0, 3'd6, 5'd0, 1'b1, 1'b0);
    fd("beq0", 32'h10220003);
    step("beq0_e", 1'b1, 1'b0, 3'd2, SA, 2'd1, 2'd0, 3'd6, 5'd0, 1'b1, 1'b0);
    fd("addi0", 32'h20000005);
    step("addi0_e", 1'b1, 1'b0, 3'd2, SA, 2'd0, 2'd2, 3'd2, 5'd0, 1'b0, 1'b0);
    step("addi0_w", 1'b1, 1'b0, 3'd4, 8'h00, 2'd0, 2'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    rtype("sub", 32'h00430822, 3'b110);
    rtype("or", 32'h00430825, 3'b001);
    rtype("and", 32'h00430824, 3'b000);
    rtype("slt", 32'h0043082A, 3'b111);
    for (int i = 0; i < 8; i++) begin
      fd("j", 32'h08000010);
      step("j_e", 1'b1, 1'b0, 3'd2, PCW, 2'd2, 2'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    end
`ifdef MULTICYCLE_CTRL_TRAP_EN
    fd("op3f", 32'hFC000000);
    for (int i = 0; i < 3; i++)
      step("halt_op", 1'b1, 1'b0, 3'd5, 8'h00, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b1);
    reset_cycle("rst_halt");
    fd("badfn", 32'h00430821);
    for (int i = 0; i < 2; i++)
      step("halt_fn", 1'b1, 1'b0, 3'd5, 8'h00, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b1);
`else
    fd("badfn", 32'h00430821);
    fd("op3f", 32'hFC000000);
    Instr = 32'h08000010;
    step("after_ill_f", 1'b0, 1'b0, 3'd0, MR, 2'd0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
`endif
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
